mygo_fifo_flex: RTL
===================

MYGO_FIFO_FLEX -- requirements
Module: mygo_fifo_flex

Interface
REQ-001 Parameter WIDTH, default 32: data width in bits; legal range >=1.
REQ-002 Parameter DEPTH, default 4: entry count; legal range >=1; non-power-of-two values SHALL be supported.
REQ-003 Parameter AF_LEVEL, default DEPTH-1: almost_full threshold; legal range 0..DEPTH.
REQ-004 Parameter AE_LEVEL, default 1: almost_empty threshold; legal range 0..DEPTH.
REQ-005 clk  input  1  sole clock; all state updates on its rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-low.
REQ-007 in_data  input  WIDTH  write data.
REQ-008 in_valid  input  1  write request.
REQ-009 in_ready  output  1  FIFO can accept a word.
REQ-010 out_data  output  WIDTH  oldest stored word.
REQ-011 out_valid  output  1  out_data holds a valid word.
REQ-012 out_ready  input  1  consumer accepts out_data.
REQ-013 flush  input  1  synchronous discard of all contents.
REQ-014 count  output  CB  occupancy; CB = max(1, clog2(DEPTH+1)).
REQ-015 almost_full  output  1  count >= AF_LEVEL.
REQ-016 almost_empty  output  1  count <= AE_LEVEL.

Function
REQ-017 The block SHALL define push = in_valid & in_ready and pop = out_valid & out_ready.
REQ-018 in_ready SHALL equal (count < DEPTH) & !flush, with no combinational path from out_ready.
REQ-019 out_valid SHALL equal (count != 0) & !flush; out_data SHALL be the entry at the read pointer.
REQ-020 A word pushed at edge N SHALL appear on out_data/out_valid after edge N (1-cycle write-to-read latency).
REQ-021 While out_valid=1 and out_ready=0, out_data SHALL hold stable.
REQ-022 Push and pop in the same cycle SHALL advance both pointers and leave count unchanged.
REQ-023 Push alone SHALL increment count; pop alone SHALL decrement count; neither SHALL leave count unchanged.
REQ-024 Pointers SHALL wrap from DEPTH-1 to 0; with DEPTH=1 both pointers SHALL remain 0.
REQ-025 When full, in_ready SHALL be 0 even if a pop occurs in that cycle; no word SHALL be overwritten.
REQ-026 flush=1 SHALL suppress any push or pop that cycle and set count and both pointers to 0 at the next edge.
REQ-027 almost_full and almost_empty SHALL derive combinationally from the count register only.
REQ-028 Storage memory SHALL NOT be reset; only pointers and count are.

Reset
REQ-029 rst=0 SHALL clear pointers and count immediately, independent of clk.
REQ-030 During and after reset: in_ready=1, out_valid=0, count=0, almost_empty=1, almost_full=(AF_LEVEL==0).
REQ-031 rst asserted mid-operation SHALL discard all stored words; the first push is accepted at the first rising edge with rst=1.

Configuration
REQ-032 Macro MYGO_FIFO_BYPASS_EN SHALL select empty-bypass mode.
REQ-033 With MYGO_FIFO_BYPASS_EN defined, when count=0 and flush=0: out_valid SHALL equal in_valid and out_data SHALL equal in_data combinationally; push and pop in the same cycle SHALL leave count at 0 and write nothing to storage.
REQ-034 Without MYGO_FIFO_BYPASS_EN, no combinational path SHALL exist from in_data/in_valid to out_data/out_valid.

Verification (WIDTH=32, DEPTH=3, AF_LEVEL=2, AE_LEVEL=1 unless noted)
REQ-035 Push 0xA1,0xA2,0xA3 with out_ready=0 -> count=3, in_ready=0, almost_full=1; drain -> 0xA1,0xA2,0xA3 in order.
REQ-036 Stream 10 words with in_valid=out_ready=1 -> all 10 output in order, pointers wrap 3 times, count never exceeds 1.
REQ-037 Full FIFO, in_valid=1, out_ready=1 for one cycle -> one pop, no push, count=2, 4th word accepted on next cycle.
REQ-038 Count=2, pulse flush with in_valid=1 and out_ready=1 -> next cycle count=0, out_valid=0, nothing popped or stored.
REQ-039 Count=2, drop rst low between edges -> count=0, out_valid=0 before next edge; after release push 0x55 -> out_data=0x55 one cycle later.
REQ-040 With MYGO_FIFO_BYPASS_EN, empty FIFO, in_valid=out_ready=1, in_data=0x77 -> out_valid=1, out_data=0x77 same cycle, count stays 0.

Source files
------------

// File: rtl/mygo_fifo_flex.sv
// Parameterised synchronous FIFO with valid/ready handshakes, synchronous flush and occupancy flags.
// Define MYGO_FIFO_BYPASS_EN to let a word pass straight through combinationally while the FIFO is empty.
module mygo_fifo_flex #(
  parameter  int WIDTH    = 32,
  parameter  int DEPTH    = 4,
  parameter  int AF_LEVEL = DEPTH - 1,
  parameter  int AE_LEVEL = 1,
  localparam int CB       = ($clog2(DEPTH + 1) > 1) ? $clog2(DEPTH + 1) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  input  logic             flush,
  output logic [CB-1:0]    count,
  output logic             almost_full,
  output logic             almost_empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [CB-1:0] DEPTH_C = CB'(DEPTH);
  localparam logic [CB-1:0] AF_C    = CB'(AF_LEVEL);
  localparam logic [CB-1:0] AE_C    = CB'(AE_LEVEL);
  localparam logic [PW-1:0] LAST_C  = PW'(DEPTH - 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CB-1:0]    r_count;

  logic w_empty;
  logic w_push;
  logic w_pop;
  logic w_skip;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] ptr);
    return (ptr == LAST_C) ? '0 : ptr + PW'(1);
  endfunction

  assign w_empty  = (r_count == '0);
  assign in_ready = (r_count < DEPTH_C) & ~flush;

`ifdef MYGO_FIFO_BYPASS_EN
  logic w_bypass;
  assign w_bypass  = w_empty & ~flush;
  assign out_valid = w_bypass ? in_valid : (~w_empty & ~flush);
  assign out_data  = w_bypass ? in_data  : r_mem[r_rd_ptr];
`else
  assign out_valid = ~w_empty & ~flush;
  assign out_data  = r_mem[r_rd_ptr];
`endif

  assign w_push = in_valid & in_ready;
  assign w_pop  = out_valid & out_ready;

`ifdef MYGO_FIFO_BYPASS_EN
  // A word handed straight through an empty FIFO never touches storage.
  assign w_skip = w_bypass & w_push & w_pop;
`else
  assign w_skip = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (!w_skip) begin
      if (w_push) r_wr_ptr <= next_ptr(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= next_ptr(r_rd_ptr);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CB'(1);
        2'b01:   r_count <= r_count - CB'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // NOTE: storage has no reset; the pointers and count alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (w_push && !w_skip) r_mem[r_wr_ptr] <= in_data;
  end

  assign count        = r_count;
  assign almost_full  = (r_count >= AF_C);
  assign almost_empty = (r_count <= AE_C);

endmodule
